// File: rtl/reu_pkg.sv
// reu_pkg: register indices and transfer-type encoding shared by the REU register block
package reu_pkg;
  localparam logic [4:0] REG_STATUS   = 5'h00;
  localparam logic [4:0] REG_CMD      = 5'h01;
  localparam logic [4:0] REG_CA_LO    = 5'h02;
  localparam logic [4:0] REG_CA_HI    = 5'h03;
  localparam logic [4:0] REG_REUA_LO  = 5'h04;
  localparam logic [4:0] REG_REUA_MID = 5'h05;
  localparam logic [4:0] REG_REUA_HI  = 5'h06;
  localparam logic [4:0] REG_LEN_LO   = 5'h07;
  localparam logic [4:0] REG_LEN_HI   = 5'h08;
  localparam logic [4:0] REG_IRQMASK  = 5'h09;
  localparam logic [4:0] REG_ADDRCTL  = 5'h0A;
  typedef enum logic [1:0] {STASH = 2'd0, FETCH = 2'd1, SWAP = 2'd2, VERIFY = 2'd3} xfer_type_e;
endpackage

// File: rtl/reu_counter.sv
// reu_counter: byte-writable up/down counter with a shadow copy for autoload
module reu_counter #(
  parameter int W = 16,
  parameter bit DOWN = 1'b0,
  parameter logic [W-1:0] RST_VAL = '0,
  localparam int NB = (W + 7) / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NB-1:0] i_we,
  input  logic [7:0]    i_wd,
  input  logic          i_reload,
  input  logic          i_step,
  output logic [W-1:0]  o_q
);
  logic [W-1:0] r_q, r_sh, w_mask, w_data;
  for (genvar b = 0; b < W; b++) begin : g_bit
    assign w_mask[b] = i_we[b/8];
    assign w_data[b] = i_wd[b%8];
  end
  // a byte write beats reload, reload beats step; writes also refresh the shadow
  always_ff @(negedge clk) begin
    if (rst) begin
      r_q  <= RST_VAL;
      r_sh <= RST_VAL;
    end else if (|i_we) begin
      r_q  <= (r_q & ~w_mask) | (w_data & w_mask);
      r_sh <= (r_sh & ~w_mask) | (w_data & w_mask);
    end else if (i_reload) r_q <= r_sh;
    else if (i_step) r_q <= DOWN ? r_q - 1'b1 : r_q + 1'b1;
  end
  assign o_q = r_q;
endmodule

// File: rtl/reu_dma_regs.sv
// reu_dma_regs: REU DMA register file with address/length counters, status and interrupt
module reu_dma_regs
  import reu_pkg::*;
#(
  parameter int REUA_W = 19,
  parameter logic [3:0] VERSION = 4'h0,
  parameter logic SIZE_BIT = 1'b1
) (
  input  logic              PHI2,
  input  logic              Reset,
  input  logic              RegRD,
  input  logic              RegWR,
  input  logic [4:0]        A,
  input  logic [7:0]        WRD,
  output logic [7:0]        RDD,
  input  logic              NextCA,
  input  logic              NextREUA,
  input  logic              XferEnd,
  input  logic              VerifyErr,
  output logic              IRQ,
  output logic              Execute,
  output logic              FF00Decode,
  output logic [1:0]        XferType,
  output logic [15:0]       CAOut,
  output logic [REUA_W-1:0] REUAOut,
  output logic              Length1
);
  logic r_exec, r_auto, r_nff00, r_ie, r_eobm, r_vem, r_ip, r_eob, r_fault;
  logic [1:0] r_inc;
  xfer_type_e r_xfer;
  logic [1:0] w_ca_we, w_len_we;
  logic [2:0] w_reua_we;
  logic [15:0] w_len;
  logic [23:0] w_reua_ext;
  logic w_wr_cmd, w_clr, w_reload, w_set_ip;
  assign w_wr_cmd  = RegWR && A == REG_CMD;
  assign w_clr     = RegRD && A == REG_STATUS;
  assign w_reload  = XferEnd && r_auto;
  assign w_set_ip  = r_ie && ((XferEnd && r_eobm) || (VerifyErr && r_vem));
  assign w_ca_we   = {RegWR && A == REG_CA_HI, RegWR && A == REG_CA_LO};
  assign w_reua_we = {RegWR && A == REG_REUA_HI, RegWR && A == REG_REUA_MID, RegWR && A == REG_REUA_LO};
  assign w_len_we  = {RegWR && A == REG_LEN_HI, RegWR && A == REG_LEN_LO};
  // a CA write cancels the whole NextCA beat, so Length holds as well
  reu_counter #(.W(16), .DOWN(1'b0), .RST_VAL(16'h0000)) u_ca (
    .clk(PHI2), .rst(Reset), .i_we(w_ca_we), .i_wd(WRD), .i_reload(w_reload),
    .i_step(NextCA && !r_inc[1]), .o_q(CAOut)
  );
  reu_counter #(.W(REUA_W), .DOWN(1'b0), .RST_VAL('0)) u_reua (
    .clk(PHI2), .rst(Reset), .i_we(w_reua_we), .i_wd(WRD), .i_reload(w_reload),
    .i_step(NextREUA && !r_inc[0]), .o_q(REUAOut)
  );
  reu_counter #(.W(16), .DOWN(1'b1), .RST_VAL(16'hFFFF)) u_len (
    .clk(PHI2), .rst(Reset), .i_we(w_len_we), .i_wd(WRD), .i_reload(w_reload),
    .i_step(NextCA && !(|w_ca_we)), .o_q(w_len)
  );
  // command, mask and address-control registers
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      r_exec  <= 1'b0;
      r_auto  <= 1'b0;
      r_nff00 <= 1'b1;
      r_xfer  <= STASH;
      r_ie    <= 1'b0;
      r_eobm  <= 1'b0;
      r_vem   <= 1'b0;
      r_inc   <= 2'b00;
    end else begin
      if (XferEnd || VerifyErr) r_exec <= 1'b0;
      else if (w_wr_cmd) r_exec <= WRD[7];
      if (w_wr_cmd) begin
        r_auto  <= WRD[5];
        r_nff00 <= WRD[4];
        r_xfer  <= xfer_type_e'(WRD[1:0]);
      end
      if (RegWR && A == REG_IRQMASK) {r_ie, r_eobm, r_vem} <= WRD[7:5];
      if (RegWR && A == REG_ADDRCTL) r_inc <= WRD[7:6];
    end
  end
  // status flags: a status read clears them and swallows any same-cycle event
  always_ff @(negedge PHI2) begin
    if (Reset || w_clr) begin
      r_ip    <= 1'b0;
      r_eob   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_ip    <= r_ip || w_set_ip;
      r_eob   <= r_eob || XferEnd;
      r_fault <= r_fault || VerifyErr;
    end
  end
  // combinational register read mux
  always_comb begin
    w_reua_ext = '1;
    w_reua_ext[REUA_W-1:0] = REUAOut;
    case (A)
      REG_STATUS:   RDD = {r_ip, r_eob, r_fault, SIZE_BIT, VERSION};
      REG_CMD:      RDD = {r_exec, 1'b1, r_auto, r_nff00, 2'b11, r_xfer};
      REG_CA_LO:    RDD = CAOut[7:0];
      REG_CA_HI:    RDD = CAOut[15:8];
      REG_REUA_LO:  RDD = w_reua_ext[7:0];
      REG_REUA_MID: RDD = w_reua_ext[15:8];
      REG_REUA_HI:  RDD = w_reua_ext[23:16];
      REG_LEN_LO:   RDD = w_len[7:0];
      REG_LEN_HI:   RDD = w_len[15:8];
      REG_IRQMASK:  RDD = {r_ie, r_eobm, r_vem, 5'b11111};
      REG_ADDRCTL:  RDD = {r_inc, 6'b111111};
      default:      RDD = 8'hFF;
    endcase
  end
  assign IRQ        = r_ip;
  assign Execute    = r_exec;
  assign FF00Decode = !r_nff00;
  assign XferType   = r_xfer;
  assign Length1    = w_len == 16'h0001;
endmodule

// File: doc/reu_dma_regs.md
REU_DMA_REGS -- requirements
Module: reu_dma_regs

Interface
REQ-001 SHALL have parameter REUA_W, default 19, REU address width (17..24).
REQ-002 SHALL have parameter VERSION, default 4'h0, status version nibble.
REQ-003 SHALL have parameter SIZE_BIT, default 1'b1, status size bit.
REQ-004 SHALL have port PHI2  in  1  system clock; all state updates on the falling edge.
REQ-005 SHALL have port Reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports RegRD and RegWR  in  1 each  register read and write strobes, one PHI2 cycle each.
REQ-007 SHALL have ports A  in  5  register index; WRD  in  8  write data; RDD  out  8  read data.
REQ-008 SHALL have ports NextCA, NextREUA, XferEnd and VerifyErr  in  1 each  transfer engine events.
REQ-009 SHALL have ports IRQ, Execute and FF00Decode  out  1 each; XferType  out  2.
REQ-010 SHALL have ports CAOut  out  16; REUAOut  out  REUA_W; Length1  out  1  (high when Length==16'h0001).

Function
REQ-011 SHALL drive RDD combinationally from A (index 0x00..0x0A) as follows:
- 0x00: {IntPending, EndOfBlock, Fault, SIZE_BIT, VERSION}
- 0x01: {Execute, 1, Autoload, nFF00, 1, 1, XferType}
- 0x02/0x03: CA lo/hi
- 0x04/0x05: REUA[7:0]/[15:8]
- 0x06: REUA[23:16], with bits at or above REUA_W reading 1
- 0x07/0x08: Length lo/hi
- 0x09: {IntEnable, EOBMask, VEMask, 5'b11111}
- 0x0A: {IncMode[1:0], 6'b111111}
- 0x0B..0x1F: 8'hFF
REQ-012 SHALL, on RegRD to 0x00, return the pre-clear value and clear IntPending, EndOfBlock and Fault at that edge.
REQ-013 SHALL, on RegWR to a counter byte (0x02..0x08), load that byte into both the live counter and its shadow.
REQ-014 SHALL, on RegWR to 0x09 only, load IntEnable=WRD[7], EOBMask=WRD[6], VEMask=WRD[5]; writes to other indices leave the masks unchanged.
REQ-015 SHALL, on RegWR to 0x0A, load IncMode=WRD[7:6]; IncMode[1]=1 fixes CA, IncMode[0]=1 fixes REUA.
REQ-016 SHALL, on RegWR to 0x01, load Execute=WRD[7], Autoload=WRD[5], nFF00=WRD[4], XferType=WRD[1:0]; FF00Decode = !nFF00.
REQ-017 SHALL, on NextCA, advance CA by 1 mod 2^16 unless IncMode[1]=1, and decrement Length by 1 mod 2^16 (0x0000 -> 0xFFFF).
REQ-018 SHALL, on NextREUA, advance REUA by 1 mod 2^REUA_W unless IncMode[0]=1.
REQ-019 SHALL, on XferEnd, set EndOfBlock and clear Execute; if Autoload=1, copy all shadows into CA, REUA and Length; otherwise hold the counters.
REQ-020 SHALL, on VerifyErr, set Fault and clear Execute; XferEnd and VerifyErr in the same cycle set both flags.
REQ-021 SHALL set IntPending at the edge an event sets EndOfBlock with EOBMask=1, or Fault with VEMask=1, when IntEnable=1.
REQ-022 SHALL drive IRQ = IntPending as a registered output.
REQ-023 SHALL apply per-counter priority: Reset > RegWR to any byte of that counter (increment or decrement fully suppressed that cycle) > XferEnd autoload > Next* step.
REQ-024 SHALL give a status-clear read priority over a same-cycle status-setting event: the event is lost.

Reset
REQ-025 SHALL, on Reset, set Execute=0, Autoload=0, nFF00=1, XferType=0, CA=0, REUA=0, Length=16'hFFFF, with the shadows set to the same values.
REQ-026 SHALL, on Reset, set IntEnable=0, EOBMask=0, VEMask=0, IncMode=0, IntPending=0, EndOfBlock=0, Fault=0, and IRQ=0.
REQ-027 SHALL let Reset asserted mid-transfer override all same-cycle strobes and events.

Structure
REQ-028 SHALL place register-index constants (REG_STATUS..REG_ADDRCTL) and the XferType encoding (STASH=0, FETCH=1, SWAP=2, VERIFY=3) in shared package reu_pkg.
REQ-029 SHALL implement CA, REUA and Length with one sub-module, reu_counter, parametrised by width and up/down direction, providing a byte-write port, shadow, reload and step.

Verification
REQ-030 SHALL verify: write 0x02=0xFF, 0x03=0x12, 0x0A=0x00, then 1 NextCA -> CAOut=0x1300, read 0x02=0x00.
REQ-031 SHALL verify: REUA_W=19, write 0x04..0x06=FF,FF,07, then NextREUA -> REUAOut=0, read 0x06=0xF8.
REQ-032 SHALL verify: Length=0x0002, Autoload=1, 2 NextCA with Length1 high after the first, then XferEnd -> Length=0x0002, CA and REUA equal shadows, Execute=0.
REQ-033 SHALL verify: write 0x09=0xC0, then XferEnd -> IRQ=1; read 0x00 returns 0xD0, next read returns 0x10.
REQ-034 SHALL verify: IncMode=2'b11, 5 NextCA plus 5 NextREUA -> CA and REUA unchanged, Length decremented by 5.
REQ-035 SHALL verify: RegWR 0x02 in the same cycle as NextCA -> CA lo = WRD, CA hi unchanged, Length unchanged.
